// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares the single-port unified memory between the core and an
// external loader/debug port with round-robin fairness and bounded bursts.
module rv_mem_arb #(
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int EXT_MAX_BURST = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ack,
   output logic [DW-1:0] ext_rdata,
   input  logic          ext_lock,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int BW = $clog2(EXT_MAX_BURST) + 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(EXT_MAX_BURST - 1);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ISSUE,
      CPU_RESP,
      EXT_ISSUE,
      EXT_RESP
   } state_t;

   state_t        state, state_nxt;
   logic          last_ext, last_ext_nxt;
   logic [BW-1:0] burst_cnt, burst_nxt;
   logic          lock_path;
   logic          op_we;
   logic [DW-1:0] cpu_rd_q, ext_rd_q;
   logic          cpu_iss, ext_iss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_ext  <= 1'b1;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         last_ext  <= last_ext_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_ext_nxt = last_ext;
      burst_nxt    = burst_cnt;
      lock_path    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_req && (!ext_req || last_ext))
               state_nxt = CPU_ISSUE;
            else if (ext_req)
               state_nxt = EXT_ISSUE;
         end
         CPU_ISSUE: state_nxt = CPU_RESP;
         EXT_ISSUE: state_nxt = EXT_RESP;
         CPU_RESP:  state_nxt = ext_req ? EXT_ISSUE : IDLE;
         EXT_RESP: begin
            if (ext_lock && ext_req && (burst_cnt < BURST_LAST)) begin
               state_nxt = EXT_ISSUE;
               lock_path = 1'b1;
            end else if (cpu_req) begin
               state_nxt = CPU_ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Grant history and burst length only move on ISSUE/IDLE entry.
      if (state_nxt == CPU_ISSUE) begin
         last_ext_nxt = 1'b0;
         burst_nxt    = '0;
      end else if (state_nxt == EXT_ISSUE) begin
         last_ext_nxt = 1'b1;
         burst_nxt    = lock_path ? burst_cnt + 1'b1 : '0;
      end else if (state_nxt == IDLE) begin
         burst_nxt    = '0;
      end
   end

   assign cpu_iss = (state == CPU_ISSUE);
   assign ext_iss = (state == EXT_ISSUE);
   assign mem_en  = cpu_iss | ext_iss;
   assign cpu_ack = (state == CPU_RESP);
   assign ext_ack = (state == EXT_RESP);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         cpu_iss: begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         ext_iss: begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
         end
         default: ;
      endcase
   end

   // Access type is latched at issue so a dropped req cannot alter the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_we    <= 1'b0;
         cpu_rd_q <= '0;
         ext_rd_q <= '0;
      end else begin
         if (mem_en)
            op_we <= mem_we;
         if (cpu_ack && !op_we)
            cpu_rd_q <= mem_rdata;
         if (ext_ack && !op_we)
            ext_rd_q <= mem_rdata;
      end
   end

   assign cpu_rdata = (cpu_ack && !op_we) ? mem_rdata : cpu_rd_q;
   assign ext_rdata = (ext_ack && !op_we) ? mem_rdata : ext_rd_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: vector table plus directed burst and reset sequences
// against a one-cycle-latency memory model.
module tb_rv_mem_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        ext_req, ext_we, ext_ack, ext_lock;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [256];
   int n_pass = 0;
   int n_tot  = 0;

   rv_mem_arb #(.AW(32), .DW(32), .EXT_MAX_BURST(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
      .ext_lock(ext_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            mem[mem_addr[9:2]] <= mem_wdata;
         else
            mem_rdata <= mem[mem_addr[9:2]];
      end
   end

   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cd;
      logic        er, ew, el;
      logic [31:0] ea, ed;
      logic [3:0]  ctl;
      logic [31:0] addr, wd, crd, erd;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(
      input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
      input logic er, input logic ew, input logic el,
      input logic [31:0] ea, input logic [31:0] ed,
      input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] wd,
      input logic [31:0] crd, input logic [31:0] erd);
      vec_t r;
      r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
      r.er = er; r.ew = ew; r.el = el; r.ea = ea; r.ed = ed;
      r.ctl = ctl; r.addr = addr; r.wd = wd; r.crd = crd; r.erd = erd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_lock = 0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs",
          {mem_en, mem_we, cpu_ack, ext_ack, 28'h0},
          64'h0);
      chk("reset_data", {mem_addr | mem_wdata, cpu_rdata | ext_rdata}, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_rows(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) begin
         cpu_req = tv[i].cr; cpu_we = tv[i].cw;
         cpu_addr = tv[i].ca; cpu_wdata = tv[i].cd;
         ext_req = tv[i].er; ext_we = tv[i].ew; ext_lock = tv[i].el;
         ext_addr = tv[i].ea; ext_wdata = tv[i].ed;
         #1;
         chk($sformatf("%s%0d_ctl", tag, i - lo),
             {60'h0, mem_en, mem_we, cpu_ack, ext_ack}, {60'h0, tv[i].ctl});
         chk($sformatf("%s%0d_addr", tag, i - lo), {32'h0, mem_addr}, {32'h0, tv[i].addr});
         chk($sformatf("%s%0d_wdata", tag, i - lo), {32'h0, mem_wdata}, {32'h0, tv[i].wd});
         chk($sformatf("%s%0d_rdata", tag, i - lo),
             {cpu_rdata, ext_rdata}, {tv[i].crd, tv[i].erd});
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] R1 = 32'h11111111;
   localparam logic [31:0] R2 = 32'h22222222;
   localparam logic [31:0] WD = 32'h00001234;

   initial begin
      int k, nb, last_en, cpu_done;
      logic own_ext, exp_ext;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[32'h10 >> 2]  = DB;
      mem[32'h100 >> 2] = R1;
      mem[32'h200 >> 2] = R2;
      mem_rdata = '0;

      // single core read, rows 0-4
      tv.push_back(v(1,0,'h10,0, 0,0,0,0,0, 4'b0000, 0,   0, 0,  0));
      tv.push_back(v(1,0,'h10,0, 0,0,0,0,0, 4'b1000, 'h10,0, 0,  0));
      tv.push_back(v(1,0,'h10,0, 0,0,0,0,0, 4'b0010, 0,   0, DB, 0));
      tv.push_back(v(0,0,'h10,0, 0,0,0,0,0, 4'b0000, 0,   0, DB, 0));
      tv.push_back(v(0,0,'h10,0, 0,0,0,0,0, 4'b0000, 0,   0, DB, 0));
      // simultaneous requests then drop during CPU_ISSUE, rows 5-17
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b0000, 0,     0, 0,  0));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b1000, 'h100, 0, 0,  0));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b0010, 0,     0, R1, 0));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b1000, 'h200, 0, R1, 0));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b0001, 0,     0, R1, R2));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b1000, 'h100, 0, R1, R2));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b0010, 0,     0, R1, R2));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b1000, 'h200, 0, R1, R2));
      tv.push_back(v(1,0,'h100,0, 1,0,0,'h200,0, 4'b0001, 0,     0, R1, R2));
      tv.push_back(v(0,0,'h100,0, 0,0,0,'h200,0, 4'b1000, 'h100, 0, R1, R2));
      tv.push_back(v(0,0,'h100,0, 0,0,0,'h200,0, 4'b0010, 0,     0, R1, R2));
      tv.push_back(v(0,0,'h100,0, 0,0,0,'h200,0, 4'b0000, 0,     0, R1, R2));
      tv.push_back(v(0,0,'h100,0, 0,0,0,'h200,0, 4'b0000, 0,     0, R1, R2));
      // ext write then core read-back, rows 18-25
      tv.push_back(v(0,0,0,0,     1,1,0,'h40,WD, 4'b0000, 0,    0,  R1, R2));
      tv.push_back(v(0,0,0,0,     1,1,0,'h40,WD, 4'b1100, 'h40, WD, R1, R2));
      tv.push_back(v(0,0,0,0,     1,1,0,'h40,WD, 4'b0001, 0,    0,  R1, R2));
      tv.push_back(v(0,0,0,0,     0,0,0,0,0,     4'b0000, 0,    0,  R1, R2));
      tv.push_back(v(1,0,'h40,0,  0,0,0,0,0,     4'b0000, 0,    0,  R1, R2));
      tv.push_back(v(1,0,'h40,0,  0,0,0,0,0,     4'b1000, 'h40, 0,  R1, R2));
      tv.push_back(v(1,0,'h40,0,  0,0,0,0,0,     4'b0010, 0,    0,  WD, R2));
      tv.push_back(v(0,0,'h40,0,  0,0,0,0,0,     4'b0000, 0,    0,  WD, R2));

      reset_dut();
      run_rows(0, 4, "rd");
      reset_dut();
      run_rows(5, 17, "rr");
      run_rows(18, 25, "wr");
      idle_inputs();

      // locked external burst of 10 writes with a core read raised at beat 2
      reset_dut();
      k = 0; nb = 0; last_en = -1; cpu_done = 0;
      for (int c = 0; c < 80 && !(k == 10 && cpu_done != 0); c++) begin
         ext_req   = (k < 10);
         ext_lock  = (k < 9);
         ext_we    = 1'b1;
         ext_addr  = 32'h300 + 32'(k * 4);
         ext_wdata = 32'hA0 + 32'(k);
         cpu_req   = (k >= 1 && cpu_done == 0);
         cpu_we    = 1'b0;
         cpu_addr  = 32'h10;
         #1;
         if (mem_en && nb < 11) begin
            own_ext = (mem_addr >= 32'h300);
            exp_ext = (nb != 8);
            chk($sformatf("burst_owner%0d", nb), {63'h0, own_ext}, {63'h0, exp_ext});
            if (exp_ext)
               chk($sformatf("burst_wdata%0d", nb), {32'h0, mem_wdata},
                   64'hA0 + 64'(nb < 8 ? nb : nb - 1));
            if (last_en >= 0)
               chk($sformatf("burst_gap%0d", nb), 64'(c - last_en), 64'd2);
            last_en = c;
            nb++;
         end
         if (ext_ack) k++;
         if (cpu_ack) begin
            chk("burst_cpu_rdata", {32'h0, cpu_rdata}, {32'h0, DB});
            cpu_done = 1;
         end
         @(posedge clk);
         #1;
      end
      chk("burst_done", {62'h0, k == 10, cpu_done != 0}, 64'h3);
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("burst_beats", 64'(nb), 64'd11);
      chk("burst_mem9", {32'h0, mem[(32'h300 >> 2) + 9]}, 64'hA9);

      // reset mid-access, then core-first tie and normal access
      reset_dut();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50; cpu_wdata = 32'h55;
      @(posedge clk);
      #1;
      chk("rst_pre_issue", {62'h0, mem_en, mem_we}, 64'h3);
      rst_n = 1'b0;
      #1;
      chk("rst_strobe_drop", {62'h0, mem_en, mem_we}, 64'h0);
      ext_req = 1; ext_we = 0; ext_addr = 32'h200;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_no_ack%0d", i), {62'h0, cpu_ack, ext_ack}, 64'h0);
      end
      chk("rst_no_write", {32'h0, mem[32'h50 >> 2]}, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_tie_cpu", {31'h0, mem_en, mem_we, mem_addr}, {31'h0, 1'b1, 1'b1, 32'h50});
      @(posedge clk);
      #1;
      chk("rst_cpu_ack", {62'h0, cpu_ack, ext_ack}, 64'h2);
      cpu_req = 0;
      chk("rst_write_done", {32'h0, mem[32'h50 >> 2]}, 64'h55);
      @(posedge clk);
      #1;
      chk("rst_ext_issue", {31'h0, mem_en, mem_we, mem_addr}, {31'h0, 1'b1, 1'b0, 32'h200});
      @(posedge clk);
      #1;
      chk("rst_ext_ack", {30'h0, cpu_ack, ext_ack, ext_rdata}, {30'h0, 1'b0, 1'b1, R2});
      ext_req = 0;
      @(posedge clk);
      #1;
      chk("rst_idle", {62'h0, mem_en, cpu_ack | ext_ack}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
